// File: rtl/wb_regfile.sv
// wb_regfile -- writeback stage register file.
//
// Selects the writeback value from the MEM/WB fields, commits it to a
// 32x32 general-purpose register file and serves the two ID-stage read
// ports with same-cycle write-through bypass. A registered debug read port
// and a committed-write counter are provided for trace use.
//
// Ports:
//   clk, rst           clock (rising edge); asynchronous active-high reset
//   WB_PC              PC of the instruction in WB (link source)
//   WB_ALU_Out         ALU result of the instruction in WB
//   WB_Read_Data       load data of the instruction in WB
//   WB_MemtoReg        source select: 00 ALU, 01 load, 10 PC+LINK_OFFSET, 11 none
//   WB_Write_Address   destination register
//   WB_RegWrite        write enable
//   Read_Address1/2    ID read port addresses
//   Read_Data1/2       ID read port data (combinational, bypassed)
//   WB_Write_Data      selected writeback value (also feeds EX forwarding)
//   WB_Commit          a register write is committed this cycle
//   Dbg_Address        debug read address
//   Dbg_Data           debug read data, registered, no bypass
//   Retire_Count       committed writes since reset, wraps at 2^32
module wb_regfile #(
  parameter int NREG        = 32,
  parameter int LINK_OFFSET = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] WB_PC,
  input  logic [31:0] WB_ALU_Out,
  input  logic [31:0] WB_Read_Data,
  input  logic [1:0]  WB_MemtoReg,
  input  logic [4:0]  WB_Write_Address,
  input  logic        WB_RegWrite,
  input  logic [4:0]  Read_Address1,
  input  logic [4:0]  Read_Address2,
  output logic [31:0] Read_Data1,
  output logic [31:0] Read_Data2,
  output logic [31:0] WB_Write_Data,
  output logic        WB_Commit,
  input  logic [4:0]  Dbg_Address,
  output logic [31:0] Dbg_Data,
  output logic [31:0] Retire_Count
);

  typedef enum logic [1:0] {
    SRC_ALU  = 2'b00,
    SRC_LOAD = 2'b01,
    SRC_LINK = 2'b10,
    SRC_NONE = 2'b11
  } wb_src_e;

  logic [31:0] regs [NREG];
  logic [31:0] retire_cnt;

  // Writeback source select.
  always_comb begin
    // NOTE: default assignment first so every path drives the output; a
    // missing branch would otherwise infer a latch.
    WB_Write_Data = '0;
    case (wb_src_e'(WB_MemtoReg))
      SRC_ALU:  WB_Write_Data = WB_ALU_Out;
      SRC_LOAD: WB_Write_Data = WB_Read_Data;
      SRC_LINK: WB_Write_Data = WB_PC + 32'(LINK_OFFSET);
      SRC_NONE: WB_Write_Data = '0;
      default:  WB_Write_Data = '0;
    endcase
  end

  // r0 is hardwired; select 11 means "no writeback".
  assign WB_Commit = WB_RegWrite && (WB_Write_Address != 5'd0) &&
                     (wb_src_e'(WB_MemtoReg) != SRC_NONE);

  // Read ports: r0 first, then same-cycle bypass, then the array.
  always_comb begin
    Read_Data1 = regs[Read_Address1];
    if (Read_Address1 == 5'd0)
      Read_Data1 = '0;
    else if (WB_Commit && (Read_Address1 == WB_Write_Address))
      Read_Data1 = WB_Write_Data;
  end

  always_comb begin
    Read_Data2 = regs[Read_Address2];
    if (Read_Address2 == 5'd0)
      Read_Data2 = '0;
    else if (WB_Commit && (Read_Address2 == WB_Write_Address))
      Read_Data2 = WB_Write_Data;
  end

  // Register array. The reset clears every entry because software relies on
  // a zeroed register file after reset; entry 0 is never written since
  // WB_Commit excludes address 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: a memory normally carries no reset; this one is deliberately
      // built from flops so all entries clear asynchronously.
      for (int i = 0; i < NREG; i++) regs[i] <= '0;
    end else if (WB_Commit) begin
      // NOTE: non-blocking assignment for all sequential state, so every
      // flop samples pre-edge values regardless of process order.
      regs[WB_Write_Address] <= WB_Write_Data;
    end
  end

  // Debug port samples pre-edge contents: a write on the same edge shows up
  // one cycle later. Address 0 naturally reads 0 as that entry never changes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) Dbg_Data <= '0;
    else     Dbg_Data <= regs[Dbg_Address];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)            retire_cnt <= '0;
    else if (WB_Commit) retire_cnt <= retire_cnt + 32'd1;
  end

  assign Retire_Count = retire_cnt;

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: a table of writeback vectors with
// hand-computed expectations, plus hand sequences for the debug-port
// latency, counter wrap and mid-stream reset.
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] WB_PC, WB_ALU_Out, WB_Read_Data;
  logic [1:0]  WB_MemtoReg;
  logic [4:0]  WB_Write_Address;
  logic        WB_RegWrite;
  logic [4:0]  Read_Address1, Read_Address2, Dbg_Address;
  logic [31:0] Read_Data1, Read_Data2, WB_Write_Data, Dbg_Data, Retire_Count;
  logic        WB_Commit;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  wb_regfile dut (
    .clk(clk), .rst(rst),
    .WB_PC(WB_PC), .WB_ALU_Out(WB_ALU_Out), .WB_Read_Data(WB_Read_Data),
    .WB_MemtoReg(WB_MemtoReg), .WB_Write_Address(WB_Write_Address),
    .WB_RegWrite(WB_RegWrite),
    .Read_Address1(Read_Address1), .Read_Address2(Read_Address2),
    .Read_Data1(Read_Data1), .Read_Data2(Read_Data2),
    .WB_Write_Data(WB_Write_Data), .WB_Commit(WB_Commit),
    .Dbg_Address(Dbg_Address), .Dbg_Data(Dbg_Data),
    .Retire_Count(Retire_Count)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled 1
  // unit later, well away from the next edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic we, input logic [1:0] ms, input logic [4:0] wa,
                       input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] rd,
                       input logic [4:0] ra1, input logic [4:0] ra2);
    WB_RegWrite = we; WB_MemtoReg = ms; WB_Write_Address = wa;
    WB_PC = pc; WB_ALU_Out = alu; WB_Read_Data = rd;
    Read_Address1 = ra1; Read_Address2 = ra2;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  ms;
    logic [4:0]  wa;
    logic [31:0] pc, alu, rd;
    logic [4:0]  ra1, ra2;
    logic [31:0] exp_wd;
    logic        exp_commit;
    logic [31:0] exp_rd1, exp_rd2;
    logic [31:0] exp_cnt;    // Retire_Count after the edge
  } vec_t;

  vec_t vecs[6];

  initial begin
    // ALU write to r5, bypassed on port 1.
    vecs[0] = '{1'b1, 2'b00, 5'd5,  32'h0, 32'h0000_1234, 32'h0, 5'd5,  5'd0,
                32'h0000_1234, 1'b1, 32'h0000_1234, 32'h0, 32'd1};
    // Link write to r31: 0x00400010 + 4; r5 now from the array.
    vecs[1] = '{1'b1, 2'b10, 5'd31, 32'h0040_0010, 32'h0, 32'h0, 5'd5, 5'd31,
                32'h0040_0014, 1'b1, 32'h0000_1234, 32'h0040_0014, 32'd2};
    // Load write to r8.
    vecs[2] = '{1'b1, 2'b01, 5'd8,  32'h0, 32'h0, 32'hDEAD_BEEF, 5'd31, 5'd8,
                32'hDEAD_BEEF, 1'b1, 32'h0040_0014, 32'hDEAD_BEEF, 32'd3};
    // Write to r0 is dropped; r0 reads 0.
    vecs[3] = '{1'b1, 2'b00, 5'd0,  32'h0, 32'hFFFF_FFFF, 32'h0, 5'd0, 5'd8,
                32'hFFFF_FFFF, 1'b0, 32'h0, 32'hDEAD_BEEF, 32'd3};
    // Select 11 to r3: value 0, no commit, no bypass.
    vecs[4] = '{1'b1, 2'b11, 5'd3,  32'h0, 32'h0000_0055, 32'h0, 5'd3, 5'd5,
                32'h0, 1'b0, 32'h0, 32'h0000_1234, 32'd3};
    // RegWrite low: value selected but not committed, no bypass.
    vecs[5] = '{1'b0, 2'b00, 5'd5,  32'h0, 32'h0000_0077, 32'h0, 5'd5, 5'd8,
                32'h0000_0077, 1'b0, 32'h0000_1234, 32'hDEAD_BEEF, 32'd3};

    rst = 1'b1;
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd0, 5'd0);
    Dbg_Address = 5'd0;
    #12;
    check("reset_count", Retire_Count, 32'h0);
    check("reset_dbg", Dbg_Data, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    tick();

    // All 32 registers read back 0 after reset on both ports.
    for (int a = 0; a < 32; a++) begin
      Read_Address1 = 5'(a);
      Read_Address2 = 5'(31 - a);
      #1;
      check($sformatf("reset_rd1_r%0d", a), Read_Data1, 32'h0);
      check($sformatf("reset_rd2_r%0d", 31 - a), Read_Data2, 32'h0);
    end

    // Table-driven writeback vectors.
    for (int i = 0; i < 6; i++) begin
      drive(vecs[i].we, vecs[i].ms, vecs[i].wa, vecs[i].pc, vecs[i].alu, vecs[i].rd,
            vecs[i].ra1, vecs[i].ra2);
      #1;
      check($sformatf("v%0d_wdata", i), WB_Write_Data, vecs[i].exp_wd);
      check($sformatf("v%0d_commit", i), 32'(WB_Commit), 32'(vecs[i].exp_commit));
      check($sformatf("v%0d_rd1", i), Read_Data1, vecs[i].exp_rd1);
      check($sformatf("v%0d_rd2", i), Read_Data2, vecs[i].exp_rd2);
      tick();
      check($sformatf("v%0d_count", i), Retire_Count, vecs[i].exp_cnt);
    end

    // r3 stayed 0 after the select-11 write; r0 still 0 via the debug port.
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd3, 5'd0);
    Dbg_Address = 5'd0;
    #1;
    check("r3_unchanged", Read_Data1, 32'h0);
    tick();
    check("dbg_r0", Dbg_Data, 32'h0);

    // Debug port latency: r7 = 0x11, then write 0xA5A5A5A5 with Dbg on r7.
    drive(1'b1, 2'b00, 5'd7, 32'h0, 32'h0000_0011, 32'h0, 5'd0, 5'd0);
    tick();
    drive(1'b1, 2'b00, 5'd7, 32'h0, 32'hA5A5_A5A5, 32'h0, 5'd7, 5'd7);
    Dbg_Address = 5'd7;
    #1;
    check("dual_bypass_rd1", Read_Data1, 32'hA5A5_A5A5);
    check("dual_bypass_rd2", Read_Data2, 32'hA5A5_A5A5);
    tick();
    check("dbg_old_value", Dbg_Data, 32'h0000_0011);
    WB_RegWrite = 1'b0;
    tick();
    check("dbg_new_value", Dbg_Data, 32'hA5A5_A5A5);
    check("count_after_r7", Retire_Count, 32'd5);

    // Counter wrap: preload the counter to all ones, then one more commit.
    force dut.retire_cnt = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt;
    #1;
    check("count_preload", Retire_Count, 32'hFFFF_FFFF);
    drive(1'b1, 2'b01, 5'd9, 32'h0, 32'h0, 32'h0000_0099, 5'd9, 5'd0);
    tick();
    check("count_wrap", Retire_Count, 32'h0);
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd5);
    Dbg_Address = 5'd9;
    tick();
    check("r9_written", Read_Data1, 32'h0000_0099);
    check("dbg_r9", Dbg_Data, 32'h0000_0099);
    check("count_after_wrap", Retire_Count, 32'h0);
    drive(1'b1, 2'b00, 5'd10, 32'h0, 32'h0000_0010, 32'h0, 5'd9, 5'd5);
    tick();
    check("count_one", Retire_Count, 32'd1);

    // Mid-cycle reset clears immediately, without waiting for an edge.
    drive(1'b0, 2'b00, 5'd0, 32'h0, 32'h0, 32'h0, 5'd9, 5'd5);
    #2;
    rst = 1'b1;
    #1;
    check("midrst_count", Retire_Count, 32'h0);
    check("midrst_dbg", Dbg_Data, 32'h0);
    check("midrst_r9", Read_Data1, 32'h0);
    check("midrst_r5", Read_Data2, 32'h0);
    // Writes blocked while rst is high.
    drive(1'b1, 2'b00, 5'd4, 32'h0, 32'h0000_0044, 32'h0, 5'd0, 5'd0);
    tick();
    WB_RegWrite = 1'b0;
    rst = 1'b0;
    Read_Address1 = 5'd4;
    #1;
    check("rst_blocks_write", Read_Data1, 32'h0);
    check("rst_blocks_count", Retire_Count, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
